// File: rtl/xbar_arbiter_pkg.sv
// Shared types and helpers for the N-port crossbar arbiter.
// The optional starvation guard is selected at build time with ARB_AGING_EN.
package xbar_arbiter_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_SEL_W     = $clog2(DEF_NUM_PORTS);

  typedef logic [DEF_SEL_W-1:0]     port_idx_t;
  typedef logic [DEF_NUM_PORTS-1:0] dst_mask_t;

  // Index of the k-th input scanned after base, wrapping at n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/xbar_out_slot.sv
// One output-port lock: remembers whether the output is owned and by
// which input. A claim always wins over a release because the arbiter
// never claims an output that is currently locked.
module xbar_out_slot
  import xbar_arbiter_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             claim_i,
  input  logic [SEL_W-1:0] claim_src_i,
  input  logic             release_i,
  output logic             active_o,
  output logic [SEL_W-1:0] mux_sel_o
);

  logic             active_q, active_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  // Next lock state: lock on claim, unlock on release, select kept on release.
  always_comb begin
    active_d = active_q;
    sel_d    = sel_q;
    if (claim_i) begin
      active_d = 1'b1;
      sel_d    = claim_src_i;
    end else if (release_i) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      active_q <= active_d;
      sel_q    <= sel_d;
    end
  end

  assign active_o  = active_q;
  assign mux_sel_o = sel_q;

endmodule

// File: rtl/xbar_arbiter.sv
// N-port crossbar arbiter: all-or-nothing multicast grants, parallel
// disjoint grants, and output locks held until the owner signals done.
// Build option ARB_AGING_EN adds per-input age counters; inputs that reach
// AGE_LIMIT are scanned first and reserve their destination outputs.
module xbar_arbiter
  import xbar_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int AGE_LIMIT = 8,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] dst,
  input  logic [NUM_PORTS-1:0]           done,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [NUM_PORTS-1:0]           active,
  output logic [NUM_PORTS*SEL_W-1:0]     mux_sel,
  output logic [SEL_W-1:0]               rr_ptr
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || AGE_LIMIT < 1) begin : g_bad_param
    $error("xbar_arbiter: NUM_PORTS must be 2..16 and AGE_LIMIT >= 1");
  end

  logic [NUM_PORTS-1:0]       active_s;
  logic [NUM_PORTS*SEL_W-1:0] mux_sel_s;
  logic [NUM_PORTS-1:0]       holding_s;
  logic [NUM_PORTS-1:0]       eligible_s;
  logic [NUM_PORTS-1:0]       aged_s;
  logic [NUM_PORTS-1:0]       grant_s;
  logic [NUM_PORTS-1:0]       busy_s;
  logic [NUM_PORTS-1:0]       reserved_s;
  logic [NUM_PORTS-1:0]       claim_s;
  logic [NUM_PORTS*SEL_W-1:0] claim_src_s;
  logic [NUM_PORTS-1:0]       release_s;
  logic [SEL_W-1:0]           rr_ptr_q, rr_ptr_d;

  // An input holds while any locked output selects it.
  always_comb begin
    holding_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        holding_s[i] = holding_s[i] |
                       (active_s[o] && (mux_sel_s[o*SEL_W +: SEL_W] == SEL_W'(i)));
      end
    end
  end

  // Eligible: requesting, not already holding, and naming at least one output.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible_s[i] = req[i] && !holding_s[i] &&
                      (dst[i*NUM_PORTS +: NUM_PORTS] != '0);
    end
  end

`ifdef ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q [NUM_PORTS];
  logic [AGE_W-1:0] age_d [NUM_PORTS];

  // Age counts waiting cycles, saturates, and clears on grant or dropped req.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_s[i] || !req[i]) begin
        age_d[i] = '0;
      end else if (eligible_s[i] && (age_q[i] != AGE_W'(AGE_LIMIT))) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  // Age counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  // An input is aged once its counter has saturated.
  always_comb begin
    aged_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      aged_s[i] = (age_q[i] == AGE_W'(AGE_LIMIT));
    end
  end
`else
  assign aged_s = '0;
`endif

  // Grant scan: aged inputs first by index (they also reserve their outputs
  // even when blocked), then the rest from rr_ptr upward with wrap. Outputs
  // being released this cycle are still active, so they are not grantable.
  always_comb begin
    grant_s    = '0;
    busy_s     = active_s;
    reserved_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      logic [NUM_PORTS-1:0] dm_v;
      logic                 take_v;
      logic                 fit_v;
      dm_v       = dst[i*NUM_PORTS +: NUM_PORTS];
      take_v     = eligible_s[i] && aged_s[i];
      fit_v      = ((dm_v & (busy_s | reserved_s)) == '0);
      grant_s[i] = take_v && fit_v;
      busy_s     = busy_s | (grant_s[i] ? dm_v : '0);
      reserved_s = reserved_s | (take_v ? dm_v : '0);
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      int                   idx_v;
      logic [NUM_PORTS-1:0] dm_v;
      logic                 win_v;
      idx_v          = wrap_idx(int'(rr_ptr_q), k, NUM_PORTS);
      dm_v           = dst[idx_v*NUM_PORTS +: NUM_PORTS];
      win_v          = eligible_s[idx_v] && !aged_s[idx_v] &&
                       ((dm_v & (busy_s | reserved_s)) == '0);
      grant_s[idx_v] = grant_s[idx_v] | win_v;
      busy_s         = busy_s | (win_v ? dm_v : '0);
    end
  end

  // Translate grants into per-output claims (grants are disjoint).
  always_comb begin
    claim_s     = '0;
    claim_src_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        logic hit_v;
        hit_v      = grant_s[i] && dst[i*NUM_PORTS + o];
        claim_s[o] = claim_s[o] | hit_v;
        claim_src_s[o*SEL_W +: SEL_W] = hit_v ? SEL_W'(i)
                                              : claim_src_s[o*SEL_W +: SEL_W];
      end
    end
  end

  // Release every locked output whose owner signals done.
  always_comb begin
    release_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        release_s[o] = release_s[o] |
                       (active_s[o] && done[i] &&
                        (mux_sel_s[o*SEL_W +: SEL_W] == SEL_W'(i)));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_slot
    xbar_out_slot #(.SEL_W(SEL_W)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .claim_i     (claim_s[o]),
      .claim_src_i (claim_src_s[o*SEL_W +: SEL_W]),
      .release_i   (release_s[o]),
      .active_o    (active_s[o]),
      .mux_sel_o   (mux_sel_s[o*SEL_W +: SEL_W])
    );
  end

  // Priority pointer advances every cycle, wrapping at NUM_PORTS-1.
  always_comb begin
    if (rr_ptr_q == SEL_W'(NUM_PORTS - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = rr_ptr_q + SEL_W'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant   = grant_s & {NUM_PORTS{rst_n}};
  assign active  = active_s;
  assign mux_sel = mux_sel_s;
  assign rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_xbar_arbiter.sv
// Self-checking bench for xbar_arbiter (4 ports): directed vector table,
// randomized traffic against a reference model, mid-run reset, and (when
// ARB_AGING_EN is defined) the starvation bound for a multicast requester.
module tb_xbar_arbiter;
  import xbar_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int AL   = 4;
  localparam int HOLD = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req, done, grant, active;
  logic [N*N-1:0]  dst;
  logic [N*SW-1:0] mux_sel;
  logic [SW-1:0]   rr_ptr;

  xbar_arbiter #(.NUM_PORTS(N), .AGE_LIMIT(AL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dst(dst), .done(done),
    .grant(grant), .active(active), .mux_sel(mux_sel), .rr_ptr(rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: owner of each output (-1 free), last owner, pointer, ages.
  int owner [N];
  int lastsel [N];
  int ptr;
  int age [N];

  typedef struct {
    logic [N-1:0]   req;
    logic [N*N-1:0] dst;
    logic [N-1:0]   done;
    logic [N-1:0]   eg;
    dst_mask_t      ea;
  } vec_t;

  vec_t tab [23];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dmask(input int p);
    return int'(dst[p*N +: N]);
  endfunction

  function automatic bit holds(input int p);
    for (int o = 0; o < N; o++) if (owner[o] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit elig(input int p);
    return req[p] && !holds(p) && (dmask(p) != 0);
  endfunction

  function automatic bit is_aged(input int p);
`ifdef ARB_AGING_EN
    return age[p] == AL;
`else
    return (p < 0);
`endif
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    int taken, resv, m, i;
    g = '0; taken = 0; resv = 0;
    for (int o = 0; o < N; o++) if (owner[o] >= 0) taken |= (1 << o);
    for (int p = 0; p < N; p++) begin
      if (elig(p) && is_aged(p)) begin
        m = dmask(p);
        if ((m & (taken | resv)) == 0) begin g[p] = 1'b1; taken |= m; end
        resv |= m;
      end
    end
    for (int k = 0; k < N; k++) begin
      i = (ptr + k) % N;
      m = dmask(i);
      if (elig(i) && !is_aged(i) && ((m & (taken | resv)) == 0)) begin
        g[i] = 1'b1; taken |= m;
      end
    end
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] g);
    bit e [N];
    int rel [N];
    for (int p = 0; p < N; p++) e[p] = elig(p);
    for (int o = 0; o < N; o++) rel[o] = (owner[o] >= 0) ? int'(done[owner[o]]) : 0;
    for (int o = 0; o < N; o++) if (rel[o] != 0) owner[o] = -1;
    for (int p = 0; p < N; p++)
      for (int o = 0; o < N; o++)
        if (g[p] && dst[p*N + o]) begin owner[o] = p; lastsel[o] = p; end
    for (int p = 0; p < N; p++) begin
      if (g[p] || !req[p]) age[p] = 0;
      else if (e[p] && age[p] < AL) age[p]++;
    end
    ptr = (ptr + 1) % N;
  endtask

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin owner[o] = -1; lastsel[o] = 0; age[o] = 0; end
    ptr = 0;
  endtask

  function automatic logic [N-1:0] exp_active();
    logic [N-1:0] a;
    for (int o = 0; o < N; o++) a[o] = (owner[o] >= 0);
    return a;
  endfunction

  function automatic logic [N*SW-1:0] exp_mux();
    logic [N*SW-1:0] m;
    for (int o = 0; o < N; o++) m[o*SW +: SW] = SW'(lastsel[o]);
    return m;
  endfunction

  // One clock: drive inputs at negedge, compare against model (and table), advance model.
  task automatic cycle(input logic [N-1:0] r, input logic [N*N-1:0] d, input logic [N-1:0] dn,
                       input bit use_tab, input logic [N-1:0] eg, input logic [N-1:0] ea,
                       input string nm, output logic [N-1:0] g_out);
    logic [N-1:0] mg;
    @(negedge clk);
    req = r; dst = d; done = dn;
    #1;
    mg = model_grant();
    check({nm, " grant"},   int'(grant),   int'(mg));
    check({nm, " active"},  int'(active),  int'(exp_active()));
    check({nm, " mux_sel"}, int'(mux_sel), int'(exp_mux()));
    check({nm, " rr_ptr"},  int'(rr_ptr),  ptr);
    if (use_tab) begin
      check({nm, " tab_grant"},  int'(grant),  int'(eg));
      check({nm, " tab_active"}, int'(active), int'(ea));
    end
    g_out = mg;
    model_step(mg);
  endtask

  function automatic logic [N*N-1:0] d4(input logic [3:0] a3, input logic [3:0] a2,
                                        input logic [3:0] a1, input logic [3:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic set_vec(input int k, input logic [N-1:0] r, input logic [N*N-1:0] d,
                         input logic [N-1:0] dn, input logic [N-1:0] eg, input logic [N-1:0] ea);
    tab[k].req = r; tab[k].dst = d; tab[k].done = dn; tab[k].eg = eg; tab[k].ea = ea;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] r;
    logic [N*N-1:0] d;
    logic [N-1:0] dn;
    int hcnt [N];
    int waited;
    bit got3;

    // Directed vectors; vector k sees rr_ptr = k mod 4 after reset release.
    set_vec( 0, 4'b0010, d4(4'b0000, 4'b0000, 4'b0100, 4'b0000), 4'b0000, 4'b0010, 4'b0000);
    set_vec( 1, 4'b0000, '0,                                     4'b0000, 4'b0000, 4'b0100);
    set_vec( 2, 4'b0000, '0,                                     4'b0010, 4'b0000, 4'b0100);
    set_vec( 3, 4'b0000, '0,                                     4'b0000, 4'b0000, 4'b0000);
    set_vec( 4, 4'b0000, '0,                                     4'b0000, 4'b0000, 4'b0000);
    set_vec( 5, 4'b0000, '0,                                     4'b0000, 4'b0000, 4'b0000);
    set_vec( 6, 4'b0101, d4(4'b0000, 4'b1000, 4'b0000, 4'b1000), 4'b0000, 4'b0100, 4'b0000);
    set_vec( 7, 4'b0001, d4(4'b0000, 4'b0000, 4'b0000, 4'b1000), 4'b0000, 4'b0000, 4'b1000);
    set_vec( 8, 4'b0001, d4(4'b0000, 4'b0000, 4'b0000, 4'b1000), 4'b0100, 4'b0000, 4'b1000);
    set_vec( 9, 4'b0001, d4(4'b0000, 4'b0000, 4'b0000, 4'b1000), 4'b0000, 4'b0001, 4'b0000);
    set_vec(10, 4'b0000, '0,                                     4'b0001, 4'b0000, 4'b1000);
    set_vec(11, 4'b0011, d4(4'b0000, 4'b0000, 4'b0001, 4'b0010), 4'b0000, 4'b0011, 4'b0000);
    set_vec(12, 4'b0000, '0,                                     4'b0001, 4'b0000, 4'b0011);
    set_vec(13, 4'b1001, d4(4'b0111, 4'b0000, 4'b0000, 4'b0010), 4'b0000, 4'b0001, 4'b0001);
    set_vec(14, 4'b1000, d4(4'b0111, 4'b0000, 4'b0000, 4'b0000), 4'b0010, 4'b0000, 4'b0011);
    set_vec(15, 4'b1000, d4(4'b0111, 4'b0000, 4'b0000, 4'b0000), 4'b0001, 4'b0000, 4'b0010);
    set_vec(16, 4'b1000, d4(4'b0111, 4'b0000, 4'b0000, 4'b0000), 4'b0000, 4'b1000, 4'b0000);
    set_vec(17, 4'b0000, '0,                                     4'b1000, 4'b0000, 4'b0111);
    set_vec(18, 4'b0100, '0,                                     4'b0000, 4'b0000, 4'b0000);
    set_vec(19, 4'b0000, '0,                                     4'b0010, 4'b0000, 4'b0000);
    set_vec(20, 4'b0001, d4(4'b0000, 4'b0000, 4'b0000, 4'b0001), 4'b0000, 4'b0001, 4'b0000);
    set_vec(21, 4'b0001, d4(4'b0000, 4'b0000, 4'b0000, 4'b0010), 4'b0001, 4'b0000, 4'b0001);
    set_vec(22, 4'b0000, '0,                                     4'b0000, 4'b0000, 4'b0000);

    rst_n = 1'b0; req = '0; dst = '0; done = '0;
    model_reset();
    repeat (3) @(negedge clk);
    req = 4'b1111; dst = '1;
    #1;
    check("reset grant",   int'(grant),   0);
    check("reset active",  int'(active),  0);
    check("reset mux_sel", int'(mux_sel), 0);
    check("reset rr_ptr",  int'(rr_ptr),  0);
    req = '0; dst = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < 23; k++)
      cycle(tab[k].req, tab[k].dst, tab[k].done, 1'b1, tab[k].eg, tab[k].ea, $sformatf("vec%0d", k), g);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      r  = N'($urandom);
      d  = (N*N)'($urandom);
      dn = N'($urandom & $urandom);
      cycle(r, d, dn, 1'b0, '0, '0, "rand", g);
    end

    // Build up locks, then reset mid-transfer: locks and pointer drop at once.
    cycle(4'b1111, d4(4'b1000, 4'b0100, 4'b0010, 4'b0001), 4'b0000, 1'b0, '0, '0, "pre_rst", g);
    cycle(4'b0000, '0, 4'b0000, 1'b0, '0, '0, "pre_rst2", g);
    @(negedge clk);
    req = 4'b1111; dst = d4(4'b1000, 4'b0100, 4'b0010, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    check("midrst grant",   int'(grant),   0);
    check("midrst active",  int'(active),  0);
    check("midrst mux_sel", int'(mux_sel), 0);
    check("midrst rr_ptr",  int'(rr_ptr),  0);
    req = '0; dst = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Multicast requester against back-to-back unicast traffic on out0/out1.
    for (int p = 0; p < N; p++) hcnt[p] = 0;
    got3 = 1'b0; waited = 0;
    for (int c = 0; c < 60 && !got3; c++) begin
      r = 4'b1011;
      d = d4(4'b0111, 4'b0000, 4'b0010, 4'b0001);
      dn = '0;
      for (int p = 0; p < 2; p++) dn[p] = holds(p) && (hcnt[p] >= HOLD);
      waited++;
      cycle(r, d, dn, 1'b0, '0, '0, "aging", g);
      got3 = g[3];
      for (int p = 0; p < 2; p++) hcnt[p] = holds(p) ? hcnt[p] + 1 : 0;
    end
`ifdef ARB_AGING_EN
    check("aging bound", int'(got3 && (waited <= AL + HOLD + 2 + N)), 1);
`endif
    cycle(4'b0000, '0, 4'b0000, 1'b0, '0, '0, "tail", g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
